// File: rtl/angle_encode.sv
// rtl/angle_encode.sv - BCD keypad entry to binary angle register writer
module angle_encode #(
  parameter int MAX_ANGLE   = 180,
  parameter int RESET_ANGLE = 90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digit_in,
  input  logic        digit_stb,
  input  logic        commit,
  input  logic        clear,
  input  logic [3:0]  sel,
  output logic [7:0]  angle1,
  output logic [7:0]  angle2,
  output logic [7:0]  angle3,
  output logic [7:0]  angle4,
  output logic [11:0] entry_bcd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [9:0] MAX_ACC = 10'(MAX_ANGLE);
  localparam logic [7:0] RST_ANG = 8'(RESET_ANGLE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV0 = 3'd1,
    CONV1 = 3'd2,
    CONV2 = 3'd3,
    CHECK = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [11:0] entry_n;
  logic [9:0]  acc, acc_n;
  logic [3:0]  target, target_n;
  logic        busy_n, done_n, err_n;
  logic        sel_onehot;
  logic [3:0]  mac_digit;
  logic [9:0]  mac_sum;
  logic [3:0]  wr_en;
  logic [7:0]  angle_q [4];

  // sel must name exactly one register before a commit is accepted
  always_comb begin
    sel_onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  end

  // one MAC step per CONV state: hundreds, then tens, then units nibble
  always_comb begin
    case (state)
      CONV0:   mac_digit = entry_bcd[11:8];
      CONV1:   mac_digit = entry_bcd[7:4];
      default: mac_digit = entry_bcd[3:0];
    endcase
    mac_sum = (acc * 10'd10) + {6'd0, mac_digit};
  end

  // next-state, entry buffer and pulse outputs
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    entry_n  = entry_bcd;
    acc_n    = acc;
    target_n = target;
    done_n   = 1'b0;
    err_n    = 1'b0;
    wr_en    = 4'd0;
    case (state)
      IDLE: begin
        if (clear) begin
          entry_n = 12'd0;
          cnt_n   = 2'd0;
        end else if (commit) begin
          if (cnt == 2'd0) begin
            // empty entry: nothing to convert, silently ignored
          end else if (!sel_onehot) begin
            err_n = 1'b1;
          end else begin
            target_n = sel;
            acc_n    = 10'd0;
            state_n  = CONV0;
          end
        end else if (digit_stb) begin
          if (digit_in > 4'd9 || cnt == 2'd3) begin
            err_n = 1'b1;
          end else begin
            entry_n = {entry_bcd[7:0], digit_in};
            cnt_n   = cnt + 2'd1;
          end
        end
      end
      CONV0: begin
        acc_n   = mac_sum;
        state_n = CONV1;
      end
      CONV1: begin
        acc_n   = mac_sum;
        state_n = CONV2;
      end
      CONV2: begin
        acc_n   = mac_sum;
        state_n = CHECK;
      end
      CHECK: begin
        if (acc > MAX_ACC) begin
          err_n = 1'b1;
        end else begin
          wr_en  = target;
          done_n = 1'b1;
        end
        entry_n = 12'd0;
        cnt_n   = 2'd0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // control/state registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      entry_bcd <= 12'd0;
      acc       <= 10'd0;
      target    <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      entry_bcd <= entry_n;
      acc       <= acc_n;
      target    <= target_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  // angle registers; wr_en is one-hot with bit 3 selecting angle1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) angle_q[i] <= RST_ANG;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[3-i]) angle_q[i] <= acc[7:0];
      end
    end
  end

  assign angle1 = angle_q[0];
  assign angle2 = angle_q[1];
  assign angle3 = angle_q[2];
  assign angle4 = angle_q[3];

endmodule

// File: tb/tb_angle_encode.sv
// tb/tb_angle_encode.sv - self-checking bench for angle_encode
module tb_angle_encode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_stb = 1'b0;
  logic        commit = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [7:0]  angle1, angle2, angle3, angle4;
  logic [11:0] entry_bcd;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  // reference model: digits typed so far and the four stored angles
  int mq[$];
  int mang[4];
  logic bh[6], dh[6], eh[6];

  angle_encode #(.MAX_ANGLE(180), .RESET_ANGLE(90)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_stb(digit_stb),
    .commit(commit), .clear(clear), .sel(sel),
    .angle1(angle1), .angle2(angle2), .angle3(angle3), .angle4(angle4),
    .entry_bcd(entry_bcd), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] model_entry();
    logic [11:0] v = 12'd0;
    for (int i = 0; i < mq.size(); i++) v = v + (12'(mq[i]) << (4 * (mq.size() - 1 - i)));
    return v;
  endfunction

  function automatic int model_value();
    int v = 0;
    int p = 1;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      v = v + mq[i] * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic logic [7:0] dut_angle(input int i);
    case (i)
      0: return angle1;
      1: return angle2;
      2: return angle3;
      default: return angle4;
    endcase
  endfunction

  function automatic int sel_index(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[3-i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) mang[i] = 90;
  endtask

  task automatic send_digit(input logic [3:0] d, output logic exp_err);
    exp_err = (d > 4'd9) || (mq.size() == 3);
    digit_in = d;
    digit_stb = 1'b1;
    @(posedge clk); #1;
    digit_stb = 1'b0;
    if (!exp_err) mq.push_back(int'(d));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    mq.delete();
  endtask

  // commit at edge E and record busy/done/err after E..E+5
  task automatic run_commit(input logic [3:0] s, input bit inject);
    sel = s;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    bh[0] = busy; dh[0] = done; eh[0] = err;
    for (int k = 1; k < 6; k++) begin
      if (inject && k == 2) begin
        digit_stb = 1'b1;
        digit_in = 4'd7;
        clear = 1'b1;
        sel = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      digit_stb = 1'b0;
      clear = 1'b0;
      bh[k] = busy; dh[k] = done; eh[k] = err;
    end
  endtask

  task automatic test_reset();
    logic [3:0] d_dummy;
    d_dummy = 4'd0;
    rst_n = 1'b0;
    #($urandom_range(3, 17));
    checks++;
    if ({angle1, angle2, angle3, angle4} !== {4{8'd90}} || entry_bcd !== 12'h000 ||
        {busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold angles=%0d,%0d,%0d,%0d entry=%h bde=%b%b%b expected 90s/000/000",
               angle1, angle2, angle3, angle4, entry_bcd, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({angle1, angle2, angle3, angle4} !== {4{8'd90}} || entry_bcd !== 12'h000 ||
        {busy, done, err} !== 3'b000 || d_dummy !== 4'd0) begin
      errors++;
      $display("FAIL reset_release angles=%0d,%0d,%0d,%0d entry=%h bde=%b%b%b expected 90s/000/000",
               angle1, angle2, angle3, angle4, entry_bcd, busy, done, err);
    end
  endtask

  task automatic test_full_entry();
    logic e;
    bit ok;
    int v, idx;
    int digs[3] = '{1, 3, 5};
    do_clear();
    foreach (digs[j]) send_digit(4'(digs[j]), e);
    checks++;
    if (entry_bcd !== 12'h135) begin
      errors++;
      $display("FAIL full_entry_bcd got %h expected 135", entry_bcd);
    end
    v = model_value();
    ok = (v <= 180);
    idx = sel_index(4'b0100);
    run_commit(4'b0100, 1'b0);
    if (ok) mang[idx] = v;
    mq.delete();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({bh[k], dh[k], eh[k]} !== {k < 4, ok && k == 4, !ok && k == 4}) begin
        errors++;
        $display("FAIL full_timing k=%0d got bde=%b%b%b expected %b%b%b", k, bh[k], dh[k], eh[k],
                 k < 4, ok && k == 4, !ok && k == 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_angle(i) !== 8'(mang[i])) begin
        errors++;
        $display("FAIL full_angle%0d got %0d expected %0d", i + 1, dut_angle(i), mang[i]);
      end
    end
    checks++;
    if (entry_bcd !== 12'h000) begin
      errors++;
      $display("FAIL full_entry_cleared got %h expected 000", entry_bcd);
    end
  endtask

  task automatic test_short_entry();
    logic e;
    bit ok;
    int v, idx;
    logic [7:0] d0 [2] = '{8'h45, 8'h00};
    int nd [2] = '{2, 1};
    logic [3:0] s [2] = '{4'b1000, 4'b0001};
    for (int c = 0; c < 2; c++) begin
      do_clear();
      for (int j = nd[c] - 1; j >= 0; j--) send_digit(d0[c][4*j +: 4], e);
      checks++;
      if (entry_bcd !== model_entry()) begin
        errors++;
        $display("FAIL short_entry_bcd case=%0d got %h expected %h", c, entry_bcd, model_entry());
      end
      v = model_value();
      ok = (v <= 180);
      idx = sel_index(s[c]);
      run_commit(s[c], 1'b0);
      if (ok) mang[idx] = v;
      mq.delete();
      for (int k = 0; k < 6; k++) begin
        checks++;
        if ({bh[k], dh[k], eh[k]} !== {k < 4, ok && k == 4, !ok && k == 4}) begin
          errors++;
          $display("FAIL short_timing case=%0d k=%0d got bde=%b%b%b expected %b%b%b", c, k,
                   bh[k], dh[k], eh[k], k < 4, ok && k == 4, !ok && k == 4);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_angle(i) !== 8'(mang[i])) begin
          errors++;
          $display("FAIL short_angle%0d case=%0d got %0d expected %0d", i + 1, c, dut_angle(i), mang[i]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic e;
    bit ok;
    int v, idx;
    logic [11:0] ent [2] = '{12'h200, 12'h180};
    for (int c = 0; c < 2; c++) begin
      do_clear();
      for (int j = 2; j >= 0; j--) send_digit(ent[c][4*j +: 4], e);
      v = model_value();
      ok = (v <= 180);
      idx = sel_index(4'b0001);
      run_commit(4'b0001, 1'b0);
      if (ok) mang[idx] = v;
      mq.delete();
      for (int k = 0; k < 6; k++) begin
        checks++;
        if ({bh[k], dh[k], eh[k]} !== {k < 4, ok && k == 4, !ok && k == 4}) begin
          errors++;
          $display("FAIL range_timing case=%0d k=%0d got bde=%b%b%b expected %b%b%b", c, k,
                   bh[k], dh[k], eh[k], k < 4, ok && k == 4, !ok && k == 4);
        end
      end
      checks++;
      if (angle4 !== 8'(mang[3]) || entry_bcd !== 12'h000) begin
        errors++;
        $display("FAIL range_angle4 case=%0d got %0d entry=%h expected %0d entry=000",
                 c, angle4, entry_bcd, mang[3]);
      end
    end
  endtask

  task automatic test_illegal_input();
    logic e;
    logic [3:0] seq [5] = '{4'd1, 4'd2, 4'd3, 4'hA, 4'd4};
    do_clear();
    // commit on an empty entry does nothing at all
    sel = 4'b0010;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL empty_commit got bde=%b%b%b expected 000", busy, done, err);
    end
    foreach (seq[j]) begin
      send_digit(seq[j], e);
      checks++;
      if (err !== e || entry_bcd !== model_entry()) begin
        errors++;
        $display("FAIL illegal_digit j=%0d err=%b entry=%h expected err=%b entry=%h",
                 j, err, entry_bcd, e, model_entry());
      end
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle got %b expected 0", err);
    end
    sel = 4'b0110;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || entry_bcd !== 12'h123) begin
      errors++;
      $display("FAIL bad_sel err=%b busy=%b entry=%h expected 1 0 123", err, busy, entry_bcd);
    end
    sel = 4'b0010;
    clear = 1'b1;
    commit = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    commit = 1'b0;
    mq.delete();
    checks++;
    if (entry_bcd !== 12'h000 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL clear_commit entry=%h busy=%b err=%b expected 000 0 0", entry_bcd, busy, err);
    end
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || angle3 !== 8'(mang[2])) begin
        errors++;
        $display("FAIL clear_commit_nowrite done=%b angle3=%0d expected 0 %0d", done, angle3, mang[2]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic e;
    bit ok;
    int v, idx;
    do_clear();
    send_digit(4'd1, e);
    send_digit(4'd2, e);
    send_digit(4'd0, e);
    v = model_value();
    ok = (v <= 180);
    idx = sel_index(4'b0010);
    run_commit(4'b0010, 1'b1);
    if (ok) mang[idx] = v;
    mq.delete();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({bh[k], dh[k], eh[k]} !== {k < 4, ok && k == 4, !ok && k == 4}) begin
        errors++;
        $display("FAIL busy_timing k=%0d got bde=%b%b%b expected %b%b%b", k, bh[k], dh[k], eh[k],
                 k < 4, ok && k == 4, !ok && k == 4);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_angle(i) !== 8'(mang[i])) begin
        errors++;
        $display("FAIL busy_angle%0d got %0d expected %0d", i + 1, dut_angle(i), mang[i]);
      end
    end
    checks++;
    if (entry_bcd !== 12'h000) begin
      errors++;
      $display("FAIL busy_entry got %h expected 000", entry_bcd);
    end
  endtask

  task automatic test_reset_abort();
    logic e;
    int seen_done;
    do_clear();
    send_digit(4'd3, e);
    send_digit(4'd3, e);
    run_commit(4'b1000, 1'b0);
    mang[0] = 33;
    mq.delete();
    checks++;
    if (angle1 !== 8'd33) begin
      errors++;
      $display("FAIL abort_setup angle1 got %0d expected 33", angle1);
    end
    send_digit(4'd1, e);
    send_digit(4'd5, e);
    send_digit(4'd0, e);
    sel = 4'b1000;
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({angle1, angle2, angle3, angle4} !== {4{8'd90}} || {busy, done, err} !== 3'b000 ||
        entry_bcd !== 12'h000) begin
      errors++;
      $display("FAIL abort_async angles=%0d,%0d,%0d,%0d bde=%b%b%b entry=%h expected 90s 000 000",
               angle1, angle2, angle3, angle4, busy, done, err, entry_bcd);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0 || {angle1, angle2, angle3, angle4} !== {4{8'd90}} || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_release done_seen=%0d angles=%0d,%0d,%0d,%0d busy=%b expected 0 90s 0",
               seen_done, angle1, angle2, angle3, angle4, busy);
    end
  endtask

  task automatic test_random();
    logic e;
    bit ok;
    int v, idx, n;
    logic [3:0] s;
    for (int it = 0; it < 40; it++) begin
      do_clear();
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        if (j == 0 && n == 3) send_digit(4'($urandom_range(0, 2)), e);
        else send_digit(4'($urandom_range(0, 9)), e);
      end
      checks++;
      if (entry_bcd !== model_entry()) begin
        errors++;
        $display("FAIL rand_entry it=%0d got %h expected %h", it, entry_bcd, model_entry());
      end
      s = 4'b0001 << $urandom_range(0, 3);
      v = model_value();
      ok = (v <= 180);
      idx = sel_index(s);
      run_commit(s, ($urandom_range(0, 3) == 0));
      if (ok) mang[idx] = v;
      mq.delete();
      checks++;
      if (dh[4] !== ok || eh[4] !== !ok || bh[3] !== 1'b1 || bh[4] !== 1'b0 || dut_angle(idx) !== 8'(mang[idx])) begin
        errors++;
        $display("FAIL rand_commit it=%0d val=%0d done=%b err=%b busy3=%b busy4=%b angle=%0d expected done=%b angle=%0d",
                 it, v, dh[4], eh[4], bh[3], bh[4], dut_angle(idx), ok, mang[idx]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_entry();
    test_short_entry();
    test_out_of_range();
    test_illegal_input();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
